// File: rtl/apollo_pkg.sv
// apollo_pkg: definitions shared by the UART transmit arbiter slice.
//   BYTE_W       : width of every data byte moved through the arbiter
//   state_t      : arbiter FSM state encoding (ST_IDLE / ST_ISSUE / ST_GAP)
//   gnt_t        : grant encoding (GNT_CTL / GNT_STR)
package apollo_pkg;

  localparam int unsigned BYTE_W = 8;

  // Plain constants rather than an enum so that legacy code comparing
  // against raw encodings keeps working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  typedef logic gnt_t;
  localparam gnt_t GNT_CTL = 1'b0;
  localparam gnt_t GNT_STR = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: single-clock byte FIFO buffering the receiver stream.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : byte at the head of the FIFO (valid while !empty)
//   full/empty : occupancy flags derived from the count
// DEPTH must be a power of 2, >= 2, so the pointers wrap naturally.
module byte_fifo
  import apollo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  // Storage needs no reset: a reset empties the FIFO via the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART transmitter between a controller (command
// responses) and a buffered receiver byte stream, spacing tx_write pulses
// BYTE_GAP clocks apart so the UART is never overrun.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ctl_data, ctl_req   : controller byte and level request (held to ack)
//   ctl_ack             : one-cycle pulse when the controller byte is sent
//   str_data, str_valid : receiver byte and one-cycle strobe
//   str_ready           : FIFO not full
//   tx_in, tx_write     : byte and one-cycle load strobe to the UART
//   ovf, ovf_clr        : sticky stream overflow flag and its clear
// Build option: define TX_ARB_RR_EN for round-robin arbitration when both
// sources are pending; otherwise the controller always has priority.
// BYTE_GAP must be >= 3.
module tx_arbiter
  import apollo_pkg::*;
#(
  parameter int unsigned BYTE_GAP = 4340,
  parameter int unsigned DEPTH    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] ctl_data,
  input  logic              ctl_req,
  output logic              ctl_ack,
  input  logic [BYTE_W-1:0] str_data,
  input  logic              str_valid,
  output logic              str_ready,
  output logic [BYTE_W-1:0] tx_in,
  output logic              tx_write,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned     GAP_W    = $clog2(BYTE_GAP);
  // IDLE + ISSUE + (BYTE_GAP-2) GAP cycles = BYTE_GAP between strobes.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 3);

  state_t            r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  gnt_t              r_gnt;
  logic [BYTE_W-1:0] r_tx_in;
  logic              r_ovf;

  logic [BYTE_W-1:0] w_fifo_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_gnt_any;
  gnt_t              w_gnt_sel;
  logic [BYTE_W-1:0] w_gnt_byte;

`ifdef TX_ARB_RR_EN
  gnt_t              r_last_gnt;
`endif

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (str_valid),
    .pop   (w_pop),
    .din   (str_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Arbitration is evaluated only in IDLE; a request withdrawn before
  // this point simply never wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_sel = GNT_CTL;
    if (r_state == ST_IDLE) begin
      if (ctl_req && !w_empty) begin
        w_gnt_any = 1'b1;
`ifdef TX_ARB_RR_EN
        w_gnt_sel = (r_last_gnt == GNT_CTL) ? GNT_STR : GNT_CTL;
`else
        w_gnt_sel = GNT_CTL;
`endif
      end else if (ctl_req) begin
        w_gnt_any = 1'b1;
        w_gnt_sel = GNT_CTL;
      end else if (!w_empty) begin
        w_gnt_any = 1'b1;
        w_gnt_sel = GNT_STR;
      end
    end
  end

  assign w_gnt_byte = (w_gnt_sel == GNT_CTL) ? ctl_data : w_fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_gnt     <= GNT_CTL;
      r_tx_in   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_any) begin
            r_state <= ST_ISSUE;
            r_gnt   <= w_gnt_sel;
            r_tx_in <= w_gnt_byte;
          end
        end
        ST_ISSUE: begin
          r_state   <= ST_GAP;
          r_gap_cnt <= '0;
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef TX_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= GNT_STR;
    end else if (w_gnt_any) begin
      r_last_gnt <= w_gnt_sel;
    end
  end
`endif

  // A set from a dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (str_valid && w_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // The FIFO head was captured into tx_in at grant; it is popped in ISSUE.
  assign w_pop     = (r_state == ST_ISSUE) && (r_gnt == GNT_STR);
  assign tx_write  = (r_state == ST_ISSUE);
  assign ctl_ack   = (r_state == ST_ISSUE) && (r_gnt == GNT_CTL);
  assign tx_in     = r_tx_in;
  assign ovf       = r_ovf;
  assign str_ready = ~w_full;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

  localparam int unsigned BG = 8;
  localparam int unsigned DP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ctl_data;
  logic       ctl_req;
  logic       ctl_ack;
  logic [7:0] str_data;
  logic       str_valid;
  logic       str_ready;
  logic [7:0] tx_in;
  logic       tx_write;
  logic       ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tx_arbiter #(
    .BYTE_GAP (BG),
    .DEPTH    (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_data  (ctl_data),
    .ctl_req   (ctl_req),
    .ctl_ack   (ctl_ack),
    .str_data  (str_data),
    .str_valid (str_valid),
    .str_ready (str_ready),
    .tx_in     (tx_in),
    .tx_write  (tx_write),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Reference model: a byte queue plus a "cycles until the next grant is
  // allowed" budget. A grant issues one cycle later and blocks further
  // grants for BYTE_GAP-1 cycles after that, giving BYTE_GAP spacing.
  logic [7:0] m_q[$];
  int         m_cool;
  bit         m_wr, m_ack, m_pop, m_ovf, m_last_str;
  logic [7:0] m_tx;

  task automatic model_reset();
    m_q.delete();
    m_cool     = 0;
    m_wr       = 0;
    m_ack      = 0;
    m_pop      = 0;
    m_ovf      = 0;
    m_tx       = 8'h00;
    m_last_str = 1;
  endtask

  task automatic model_edge();
    bit full, nonempty, g_ctl, g_str;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full     = (m_q.size() == DP);
    nonempty = (m_q.size() != 0);
    g_ctl = 0;
    g_str = 0;
    if (m_cool == 0) begin
      if (ctl_req && nonempty) begin
`ifdef TX_ARB_RR_EN
        if (m_last_str) g_ctl = 1; else g_str = 1;
`else
        g_ctl = 1;
`endif
      end else if (ctl_req) begin
        g_ctl = 1;
      end else if (nonempty) begin
        g_str = 1;
      end
    end else begin
      m_cool--;
    end
    if (g_ctl) m_tx = ctl_data;
    if (g_str) m_tx = m_q[0];
    if (m_wr && m_pop) void'(m_q.pop_front());
    m_wr  = g_ctl | g_str;
    m_ack = g_ctl;
    m_pop = g_str;
    if (g_ctl | g_str) begin
      m_cool     = BG - 1;
      m_last_str = g_str;
    end
    if (str_valid && full) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (str_valid && !full) m_q.push_back(str_data);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    ctl_req   = 1'b0;
    ctl_data  = 8'h00;
    str_valid = 1'b0;
    str_data  = 8'h00;
    ovf_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) step();
    checks++; if (tx_in !== 8'h00) begin errors++; $display("FAIL reset_tx_in got=%h exp=00", tx_in); end
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL reset_tx_write got=%b exp=0", tx_write); end
    checks++; if (ctl_ack !== 1'b0) begin errors++; $display("FAIL reset_ctl_ack got=%b exp=0", ctl_ack); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (str_ready !== 1'b1) begin errors++; $display("FAIL reset_str_ready got=%b exp=1", str_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ctl_single();
    int gap;
    ctl_req  = 1'b1;
    ctl_data = 8'hA5;
    step();
    checks++; if (tx_write !== 1'b1) begin errors++; $display("FAIL ctl_tx_write got=%b exp=1", tx_write); end
    checks++; if (ctl_ack !== 1'b1) begin errors++; $display("FAIL ctl_ack got=%b exp=1", ctl_ack); end
    checks++; if (tx_in !== 8'hA5) begin errors++; $display("FAIL ctl_tx_in got=%h exp=a5", tx_in); end
    // Controller immediately presents its next byte.
    ctl_data = 8'h5A;
    gap = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tx_write) begin
        gap = i;
        break;
      end
    end
    ctl_req = 1'b0;
    checks++; if (gap !== BG) begin errors++; $display("FAIL ctl_spacing got=%0d exp=%0d", gap, BG); end
    checks++; if (tx_in !== 8'h5A) begin errors++; $display("FAIL ctl_second_byte got=%h exp=5a", tx_in); end
    repeat (BG) step();
  endtask

  task automatic test_stream_order();
    int         wt[$];
    logic [7:0] wd[$];
    for (int i = 0; i < 40; i++) begin
      str_valid = (i < 3);
      str_data  = 8'(i + 1);
      step();
      if (tx_write) begin
        wt.push_back(i);
        wd.push_back(tx_in);
      end
    end
    str_valid = 1'b0;
    checks++; if (wt.size() != 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", wt.size()); end
    if (wt.size() == 3) begin
      checks++; if (wt[0] != 1) begin errors++; $display("FAIL stream_latency got=%0d exp=1", wt[0]); end
      checks++; if (wt[1] - wt[0] != BG) begin errors++; $display("FAIL stream_gap1 got=%0d exp=%0d", wt[1] - wt[0], BG); end
      checks++; if (wt[2] - wt[0] != 2 * BG) begin errors++; $display("FAIL stream_gap2 got=%0d exp=%0d", wt[2] - wt[0], 2 * BG); end
      for (int k = 0; k < 3; k++) begin
        checks++; if (wd[k] !== 8'(k + 1)) begin errors++; $display("FAIL stream_data%0d got=%h exp=%h", k, wd[k], 8'(k + 1)); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] wd[$];
    ctl_req  = 1'b1;
    ctl_data = 8'h3C;
    step();
    ctl_req = 1'b0;
    checks++; if (tx_write !== 1'b1) begin errors++; $display("FAIL ovf_ctl_issue got=%b exp=1", tx_write); end
    // Five strobes land inside the gap, so nothing can drain.
    for (int i = 0; i < 5; i++) begin
      str_valid = 1'b1;
      str_data  = 8'(8'h10 + i);
      step();
    end
    str_valid = 1'b0;
    checks++; if (str_ready !== 1'b0) begin errors++; $display("FAIL ovf_str_ready got=%b exp=0", str_ready); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_write) wd.push_back(tx_in);
    end
    checks++; if (wd.size() != 4) begin errors++; $display("FAIL ovf_stored got=%0d exp=4", wd.size()); end
    if (wd.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (wd[k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL ovf_data%0d got=%h exp=%h", k, wd[k], 8'(8'h10 + k)); end
      end
    end
    checks++; if (str_ready !== 1'b1) begin errors++; $display("FAIL ovf_drained_ready got=%b exp=1", str_ready); end
  endtask

  task automatic test_arbitration();
    logic       ga[3];
    logic [7:0] gd[3];
    int n;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    ctl_req  = 1'b1;
    ctl_data = 8'hC1;
    for (int i = 0; i < 60; i++) begin
      str_valid = (i < 2);
      str_data  = 8'(8'hD1 + i);
      step();
      if (tx_write) begin
        if (n < 3) begin
          ga[n] = ctl_ack;
          gd[n] = tx_in;
        end
        n++;
        if (ctl_ack) begin
          if (n >= 3) ctl_req = 1'b0;
          else ctl_data = ctl_data + 8'h01;
        end
      end
    end
    str_valid = 1'b0;
    ctl_req   = 1'b0;
    checks++; if (n < 3) begin errors++; $display("FAIL arb_issues got=%0d exp>=3", n); end
    if (n >= 3) begin
`ifdef TX_ARB_RR_EN
      checks++; if ({ga[0], ga[1], ga[2]} !== 3'b101) begin errors++; $display("FAIL arb_rr_acks got=%b%b%b exp=101", ga[0], ga[1], ga[2]); end
      checks++; if (gd[1] !== 8'hD1) begin errors++; $display("FAIL arb_rr_byte2 got=%h exp=d1", gd[1]); end
      checks++; if (gd[2] !== 8'hC2) begin errors++; $display("FAIL arb_rr_byte3 got=%h exp=c2", gd[2]); end
`else
      checks++; if ({ga[0], ga[1], ga[2]} !== 3'b111) begin errors++; $display("FAIL arb_fixed_acks got=%b%b%b exp=111", ga[0], ga[1], ga[2]); end
      checks++; if (gd[1] !== 8'hC2) begin errors++; $display("FAIL arb_fixed_byte2 got=%h exp=c2", gd[1]); end
      checks++; if (gd[2] !== 8'hC3) begin errors++; $display("FAIL arb_fixed_byte3 got=%h exp=c3", gd[2]); end
`endif
    end
  endtask

  task automatic test_reset_mid_gap();
    int wr_cnt;
    for (int i = 0; i < 3; i++) begin
      str_valid = 1'b1;
      str_data  = 8'(8'h71 + i);
      step();
    end
    str_valid = 1'b0;
    repeat (2) step();
    checks++; if (str_ready !== 1'b1 || tx_write !== 1'b0) begin errors++; $display("FAIL midgap_pre got=%b%b exp=10", str_ready, tx_write); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (tx_in !== 8'h00) begin errors++; $display("FAIL midgap_tx_in got=%h exp=00", tx_in); end
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL midgap_tx_write got=%b exp=0", tx_write); end
    checks++; if (ctl_ack !== 1'b0) begin errors++; $display("FAIL midgap_ctl_ack got=%b exp=0", ctl_ack); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midgap_ovf got=%b exp=0", ovf); end
    checks++; if (str_ready !== 1'b1) begin errors++; $display("FAIL midgap_str_ready got=%b exp=1", str_ready); end
    step();
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 3 * BG; i++) begin
      step();
      if (tx_write) wr_cnt++;
    end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL midgap_no_write got=%0d exp=0", wr_cnt); end
    ctl_req  = 1'b1;
    ctl_data = 8'hEE;
    step();
    ctl_req = 1'b0;
    checks++; if (tx_write !== 1'b1 || tx_in !== 8'hEE) begin errors++; $display("FAIL midgap_new_req got=%b/%h exp=1/ee", tx_write, tx_in); end
    repeat (BG) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      // Controller behaviour: hold until ack, occasionally withdraw early.
      if (ctl_ack) ctl_req = 1'b0;
      else if (!ctl_req && $urandom_range(0, 3) == 0) begin
        ctl_req  = 1'b1;
        ctl_data = 8'($urandom);
      end else if (ctl_req && $urandom_range(0, 15) == 0) ctl_req = 1'b0;
      str_valid = ($urandom_range(0, 2) == 0);
      str_data  = 8'($urandom);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      step();
      checks++; if (tx_write !== m_wr) begin errors++; $display("FAIL rand_tx_write cyc=%0d got=%b exp=%b", cyc, tx_write, m_wr); end
      checks++; if (ctl_ack !== m_ack) begin errors++; $display("FAIL rand_ctl_ack cyc=%0d got=%b exp=%b", cyc, ctl_ack, m_ack); end
      checks++; if (tx_in !== m_tx) begin errors++; $display("FAIL rand_tx_in cyc=%0d got=%h exp=%h", cyc, tx_in, m_tx); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf); end
      checks++; if (str_ready !== (m_q.size() < DP)) begin errors++; $display("FAIL rand_str_ready cyc=%0d got=%b exp=%b", cyc, str_ready, m_q.size() < DP); end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_ctl_single();
    test_stream_order();
    test_overflow();
    test_arbitration();
    test_reset_mid_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter BYTE_GAP, default 4340, giving the minimum clk cycles between tx_write pulses (one UART frame at 115200 baud, 50 MHz).
REQ-002 SHALL have parameter DEPTH, default 16, giving the stream FIFO depth in bytes (power of 2, >=2).
REQ-003 SHALL have port clk  in  1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1, reset, asynchronous, active-low.
REQ-005 SHALL have port ctl_data  in  8, the command-response byte from the controller.
REQ-006 SHALL have port ctl_req  in  1, a level request; held until ctl_ack.
REQ-007 SHALL have port ctl_ack  out  1, a one-cycle pulse when ctl_data is issued.
REQ-008 SHALL have port str_data  in  8, the receiver output byte.
REQ-009 SHALL have port str_valid  in  1, a one-cycle strobe per receiver byte.
REQ-010 SHALL have port str_ready  out  1, the FIFO-not-full indication.
REQ-011 SHALL have port tx_in  out  8, the byte to the UART transmitter.
REQ-012 SHALL have port tx_write  out  1, a one-cycle UART load strobe.
REQ-013 SHALL have port ovf  out  1, a sticky stream-overflow flag.
REQ-014 SHALL have port ovf_clr  in  1, a synchronous clear for ovf.

Function
REQ-015 SHALL push str_data into the FIFO when str_valid=1 and the FIFO is not full; str_ready = !full, combinational from the count.
REQ-016 SHALL drop the byte and set ovf when str_valid=1 while full; ovf_clr in the same cycle loses to the set.
REQ-017 SHALL implement FSM IDLE -> ISSUE -> GAP -> IDLE.
REQ-018 In IDLE, SHALL grant ctl when ctl_req=1, else the stream when the FIFO is non-empty, else remain in IDLE.
REQ-019 On grant, SHALL register the granted byte into tx_in and pulse tx_write the next cycle (ISSUE), giving latency 1 cycle from the IDLE grant.
REQ-020 In ISSUE, SHALL pulse ctl_ack when ctl is granted, or pop the FIFO when the stream is granted; pop and push in the same cycle keep the count unchanged.
REQ-021 In GAP, SHALL count BYTE_GAP-2 cycles and then return to IDLE, so tx_write pulses are spaced exactly BYTE_GAP cycles under continuous load.
REQ-022 tx_in SHALL hold its last value outside ISSUE; tx_write and ctl_ack SHALL be 0 outside ISSUE.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-024 ctl_req deasserted before grant SHALL be ignored (no ack, no issue).

Reset
REQ-025 While rst_n=0: state IDLE, gap counter 0, FIFO empty, tx_in=8'h00, tx_write=0, ctl_ack=0, ovf=0, str_ready=1.
REQ-026 Reset mid-GAP or mid-ISSUE SHALL abort; FIFO contents are discarded and no partial pulse remains.

Configuration
REQ-027 With TX_ARB_RR_EN defined, SHALL replace fixed priority with round-robin: when both requesters are pending in IDLE, grant the one not granted last (1-bit last-grant register, reset to stream).
REQ-028 Without TX_ARB_RR_EN, ctl SHALL always win (REQ-018); the last-grant register SHALL be absent.

Structure
REQ-029 Shared package apollo_pkg SHALL hold BYTE_W=8, the FSM state encoding (IDLE/ISSUE/GAP) and the grant encoding (GNT_CTL/GNT_STR).
REQ-030 The FIFO SHALL be sub-module byte_fifo (DEPTH parameter; push, pop, din, dout, full, empty); the arbiter FSM and gap counter SHALL stay in tx_arbiter.

Verification (bench uses BYTE_GAP=8, DEPTH=4)
REQ-031 ctl_req=1, ctl_data=8'hA5 from IDLE -> tx_in=8'hA5 with tx_write=1 and ctl_ack=1 one cycle later; next tx_write no sooner than 8 cycles after.
REQ-032 Stream bytes 01,02,03 pushed back-to-back -> tx_write at t, t+8, t+16 with tx_in 01,02,03 in order.
REQ-033 5 str_valid strobes with no drain (ctl holding the bus) -> 4 stored, str_ready=0, ovf=1; ovf_clr=1 -> ovf=0.
REQ-034 Both ctl_req and FIFO pending -> default build: ctl issued twice consecutively; with TX_ARB_RR_EN: ctl and stream alternate.
REQ-035 rst_n=0 asserted 3 cycles into GAP with 2 bytes queued -> all outputs at reset values; after release no tx_write until a new request.
